// File: rtl/dot_sequencer.sv
// dot_sequencer: collects H element pairs into a/b vectors, drives a level-sensitive
// start to an external dot-product engine, captures its result and hands it downstream
// with a valid/ready handshake. A CLEAR state waits for the engine's done level to drop
// so a stale done cannot terminate the following run.
//
// Optional feature macro: DOT_SEQ_TIMEOUT_EN
//   When defined, a RUN-state watchdog of TMO_CYCLES cycles is built and the res_err
//   port exists; an expired run produces res_data=0 with res_err=1.

module dot_sequencer #(
    parameter int unsigned Q          = 15,   // fractional bits, carried for the engine only
    parameter int unsigned N          = 32,
    parameter int unsigned H          = 10,
    parameter int unsigned TMO_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_a,
    input  logic [N-1:0]          in_b,
    output logic [H-1:0][N-1:0]   a_vec,
    output logic [H-1:0][N-1:0]   b_vec,
    output logic                  start_dot,
    input  logic                  dot_done,
    input  logic [N-1:0]          dot_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [N-1:0]          res_data,
`ifdef DOT_SEQ_TIMEOUT_EN
    output logic                  res_err,
`endif
    output logic                  busy
);

    localparam int unsigned IdxW = (H > 1) ? $clog2(H) : 1;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StRun   = 2'd1,
        StOut   = 2'd2,
        StClear = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [H-1:0][N-1:0]  a_q, b_q;
    logic [N-1:0]         res_q, res_d;
    logic                 accept;
    logic                 tmo_hit;

    // Q is a pass-through attribute of the data format; nothing here depends on it.
    logic [31:0] unused_q;
    assign unused_q = Q;

`ifdef DOT_SEQ_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TMO_CYCLES + 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;

    // Watchdog: counts RUN cycles, held at zero elsewhere so it restarts on every RUN entry.
    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        err_d   = err_q;
        if (state_q == StRun) begin
            tmo_d   = tmo_q + 1'b1;
            tmo_hit = !dot_done && (tmo_q == TmoW'(TMO_CYCLES - 1));
            if (dot_done) begin
                err_d = 1'b0;
            end else if (tmo_hit) begin
                err_d = 1'b1;
            end
        end
    end

    // Watchdog counter and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign res_err = err_q;
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = TMO_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    // Next-state logic: load index, state transitions and result capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        res_d   = res_q;
        accept  = 1'b0;
        unique case (state_q)
            StLoad: begin
                // dot_done is deliberately not looked at here.
                if (in_valid) begin
                    accept = 1'b1;
                    if (idx_q == IdxW'(H - 1)) begin
                        idx_d   = '0;
                        state_d = StRun;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StRun: begin
                if (dot_done) begin
                    res_d   = dot_result;
                    state_d = StOut;
                end else if (tmo_hit) begin
                    res_d   = '0;
                    state_d = StOut;
                end
            end
            StOut: begin
                if (res_ready) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                if (!dot_done) begin
                    state_d = StLoad;
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // State, index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoad;
            idx_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end

    // Vector storage: written only on LOAD acceptances, held in every other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            a_q[idx_q] <= in_a;
            b_q[idx_q] <= in_b;
        end
    end

    // Outputs are pure functions of the registered state.
    always_comb begin
        in_ready  = (state_q == StLoad);
        start_dot = (state_q == StRun);
        res_valid = (state_q == StOut);
        busy      = (state_q != StLoad);
        res_data  = res_q;
        a_vec     = a_q;
        b_vec     = b_q;
    end

endmodule

// File: tb/tb_dot_sequencer.sv
// Testbench for dot_sequencer (H=4, N=32): table-driven transactions, hand-written
// reset / stale-done / timeout sequences, and randomized transactions checked against
// a queue-based model of what was offered and accepted.

module tb_dot_sequencer;

    localparam int unsigned N   = 32;
    localparam int unsigned H   = 4;
    localparam int unsigned Q   = 15;
    localparam int unsigned TMO = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [N-1:0]         in_a = '0;
    logic [N-1:0]         in_b = '0;
    logic [H-1:0][N-1:0]  a_vec;
    logic [H-1:0][N-1:0]  b_vec;
    logic                 start_dot;
    logic                 dot_done = 1'b0;
    logic [N-1:0]         dot_result = '0;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [N-1:0]         res_data;
    logic                 busy;
`ifdef DOT_SEQ_TIMEOUT_EN
    logic                 res_err;
`endif

    dot_sequencer #(
        .Q          (Q),
        .N          (N),
        .H          (H),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .a_vec      (a_vec),
        .b_vec      (b_vec),
        .start_dot  (start_dot),
        .dot_done   (dot_done),
        .dot_result (dot_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
`ifdef DOT_SEQ_TIMEOUT_EN
        .res_err    (res_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [H-1:0][N-1:0] a;
        logic [H-1:0][N-1:0] b;
        logic [N-1:0]        r;
        int                  mode;     // 0 back-to-back, 1 alternate, 2 random valid
        int                  dly;      // RUN cycles before done
        int                  bp;       // cycles res_ready held low
        int                  hold;     // CLEAR cycles done stays high
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers the H pairs under the chosen valid pattern; the model records what it
    // expects to be accepted (everything offered while LOAD) and returns the vectors.
    task automatic load_phase(input logic [H-1:0][N-1:0] a, input logic [H-1:0][N-1:0] b,
                              input int mode, output logic [H*N-1:0] ea,
                              output logic [H*N-1:0] eb);
        logic [N-1:0] qa[$];
        logic [N-1:0] qb[$];
        int cyc;
        logic v;
        cyc = 0;
        ea  = '0;
        eb  = '0;
        while (qa.size() < H && cyc < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 1;
                default: v = 1'($urandom % 2);
            endcase
            in_valid = v;
            in_a     = a[qa.size()];
            in_b     = b[qb.size()];
            check("in_ready_load", in_ready, 1);
            step();
            cyc++;
            if (v) begin
                qa.push_back(in_a);
                qb.push_back(in_b);
            end
            if (qa.size() < H) check("start_low_in_load", start_dot, 0);
        end
        in_valid = 1'b0;
        check("load_completed", qa.size(), H);
        for (int k = 0; k < qa.size(); k++) begin
            ea[k*N +: N] = qa[k];
            eb[k*N +: N] = qb[k];
        end
        check("start_dot_after_last", start_dot, 1);
        check("in_ready_run", in_ready, 0);
        check("busy_run", busy, 1);
        check("a_vec", a_vec, ea);
        check("b_vec", b_vec, eb);
    endtask

    task automatic run_txn(input vec_t t);
        logic [H*N-1:0] ea, eb;
        load_phase(t.a, t.b, t.mode, ea, eb);
        dot_done = 1'b0;
        for (int i = 0; i < t.dly; i++) begin
            step();
            check("start_held", start_dot, 1);
            check("no_res_in_run", res_valid, 0);
        end
        dot_done   = 1'b1;
        dot_result = t.r;
        step();
        dot_result = $urandom;
        dot_done   = (t.hold > 0);
        check("res_valid", res_valid, 1);
        check("start_dropped", start_dot, 0);
        check("res_data", res_data, t.r);
`ifdef DOT_SEQ_TIMEOUT_EN
        check("res_err_normal", res_err, 0);
`endif
        // Junk offered during OUT must not be taken.
        in_valid  = 1'b1;
        in_a      = $urandom;
        in_b      = $urandom;
        res_ready = 1'b0;
        for (int i = 0; i < t.bp; i++) begin
            step();
            check("res_stable", res_data, t.r);
            check("res_valid_bp", res_valid, 1);
            check("in_ready_out", in_ready, 0);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("clear_res_valid", res_valid, 0);
        check("clear_in_ready", in_ready, 0);
        check("clear_start", start_dot, 0);
        for (int i = 0; i < t.hold; i++) begin
            step();
            check("clear_wait_done", in_ready, 0);
        end
        dot_done = 1'b0;
        step();
        in_valid = 1'b0;
        check("back_to_load", in_ready, 1);
        check("busy_load", busy, 0);
        check("a_vec_held", a_vec, ea);
        check("b_vec_held", b_vec, eb);
    endtask

    initial begin
        vec_t rt;

        tbl[0].a = {4{32'h0000_8000}};
        tbl[0].b = {4{32'h0000_8000}};
        tbl[0].r = 32'h0002_0000;
        tbl[0].mode = 0; tbl[0].dly = 0; tbl[0].bp = 0; tbl[0].hold = 0;

        tbl[1].a = {32'h4, 32'h3, 32'h2, 32'h1};
        tbl[1].b = {32'h40, 32'h30, 32'h20, 32'h10};
        tbl[1].r = 32'hdead_beef;
        tbl[1].mode = 1; tbl[1].dly = 3; tbl[1].bp = 10; tbl[1].hold = 3;

        tbl[2].a = {32'hffff_ffff, 32'h8000_0000, 32'h0, 32'h7fff_ffff};
        tbl[2].b = {32'h0000_0001, 32'hffff_fffe, 32'h5555_5555, 32'haaaa_aaaa};
        tbl[2].r = 32'hffff_ffff;
        tbl[2].mode = 0; tbl[2].dly = 1; tbl[2].bp = 2; tbl[2].hold = 1;

        tbl[3].a = {32'h0bad_0004, 32'h0bad_0003, 32'h0bad_0002, 32'h0bad_0001};
        tbl[3].b = {32'h1234_0004, 32'h1234_0003, 32'h1234_0002, 32'h1234_0001};
        tbl[3].r = 32'h1234_5678;
        tbl[3].mode = 1; tbl[3].dly = 0; tbl[3].bp = 0; tbl[3].hold = 0;

        // Reset values.
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_start", start_dot, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_busy", busy, 0);
        check("rst_a_vec", a_vec, 0);
        check("rst_b_vec", b_vec, 0);
`ifdef DOT_SEQ_TIMEOUT_EN
        check("rst_res_err", res_err, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) run_txn(tbl[i]);

        // A done level seen in LOAD changes nothing and captures nothing.
        dot_done   = 1'b1;
        dot_result = 32'h0bad_0bad;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ld_done_busy", busy, 0);
            check("ld_done_ready", in_ready, 1);
            check("ld_done_res_valid", res_valid, 0);
            check("ld_done_res_data", res_data, tbl[3].r);
        end
        dot_done = 1'b0;
        run_txn(tbl[0]);

        // Reset after two acceptances discards the partial vector.
        in_valid = 1'b1;
        in_a = 32'h1111_1111;
        in_b = 32'h2222_2222;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midload_rst_a", a_vec, 0);
        check("midload_rst_b", b_vec, 0);
        check("midload_rst_ready", in_ready, 1);
        check("midload_rst_data", res_data, 0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        run_txn(tbl[2]);

        // Reset in the middle of a run drops the pending work.
        in_valid = 1'b1;
        for (int i = 0; i < H; i++) step();
        in_valid = 1'b0;
        check("pre_rst_run", start_dot, 1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_start", start_dot, 0);
        check("midrun_rst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        step();

`ifdef DOT_SEQ_TIMEOUT_EN
        begin
            logic [H*N-1:0] ea, eb;
            load_phase(tbl[1].a, tbl[1].b, 0, ea, eb);
            dot_done = 1'b0;
            for (int i = 1; i < TMO; i++) begin
                step();
                check("tmo_still_run", start_dot, 1);
                check("tmo_no_res", res_valid, 0);
            end
            step();
            check("tmo_res_valid", res_valid, 1);
            check("tmo_res_err", res_err, 1);
            check("tmo_res_data", res_data, 0);
            check("tmo_start", start_dot, 0);
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            step();
            check("tmo_back_load", in_ready, 1);
            check("tmo_vec_held", a_vec, ea);
        end
`endif

        // Randomized transactions.
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < H; k++) begin
                rt.a[k] = $urandom;
                rt.b[k] = $urandom;
            end
            rt.r    = $urandom;
            rt.mode = 2;
            rt.dly  = int'($urandom_range(0, 4));
            rt.bp   = int'($urandom_range(0, 4));
            rt.hold = int'($urandom_range(0, 3));
            run_txn(rt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
